// File: rtl/opcode_decode_pkg.sv
// Shared constants and trap FSM state type for the opcode decode stage.
package opcode_decode_pkg;

  localparam int OPCODE_W_DEF = 3;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } trap_state_e;

endpackage

// File: rtl/opcode_decode_stage_onehot_dec.sv
// Combinational one-hot decode with legality check against LEGAL_MASK.
module onehot_dec #(
  parameter int                         OPCODE_W   = 3,
  parameter logic [(2**OPCODE_W)-1:0]   LEGAL_MASK = '1
) (
  input  logic [OPCODE_W-1:0]      opcode,
  output logic [(2**OPCODE_W)-1:0] onehot,
  output logic                     illegal
);

  localparam int NUM_OPS = 2**OPCODE_W;

  assign illegal = !LEGAL_MASK[opcode];
  // Illegal opcodes decode to all-zero so downstream never sees a stray select.
  assign onehot  = illegal ? '0 : (NUM_OPS'(1) << opcode);

endmodule

// File: rtl/opcode_decode_stage.sv
// One-cycle registered opcode decode stage with saturating accept counter.
// Optional illegal-opcode trap FSM enabled by defining OPCODE_DECODE_TRAP_EN.
module opcode_decode_stage
  import opcode_decode_pkg::*;
#(
  parameter int                 OPCODE_W   = OPCODE_W_DEF,
  parameter int                 NUM_OPS    = 2**OPCODE_W,
  parameter logic [NUM_OPS-1:0] LEGAL_MASK = '1,
  parameter int                 CNT_W      = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_OPS-1:0]  out_onehot,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    op_count,
  output logic                trap,
  input  logic                trap_clr
);

  logic [NUM_OPS-1:0] dec_onehot;
  logic               dec_illegal;
  logic               accept;

  onehot_dec #(
    .OPCODE_W   (OPCODE_W),
    .LEGAL_MASK (LEGAL_MASK)
  ) u_dec (
    .opcode  (in_opcode),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  // Reset gates in_ready so nothing is accepted while the stage is held.
  assign in_ready = rst_n && (!out_valid || out_ready) && !trap;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_onehot  <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_onehot  <= dec_onehot;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      // Clear payload with valid so idle outputs read as zero.
      out_valid   <= 1'b0;
      out_onehot  <= '0;
      out_illegal <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      op_count <= '0;
    else if (accept && (op_count != {CNT_W{1'b1}}))
      op_count <= op_count + 1'b1;
  end

`ifdef OPCODE_DECODE_TRAP_EN
  trap_state_e state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (accept && dec_illegal) state_q <= TRAP;
        TRAP:    if (trap_clr)              state_q <= RUN;
        default:                            state_q <= RUN;
      endcase
    end
  end

  assign trap = (state_q == TRAP);
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap            = 1'b0;
`endif

endmodule

// File: doc/opcode_decode_stage.md
OPCODE_DECODE_STAGE -- requirements
Module: opcode_decode_stage

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 3, giving the opcode width in bits (legal range 1..6).
REQ-002 The block SHALL have parameter NUM_OPS, default 2**OPCODE_W, giving the one-hot output width; it is derived and never overridden.
REQ-003 The block SHALL have parameter LEGAL_MASK, NUM_OPS bits wide, default all ones; bit k=1 marks opcode k legal.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the accepted-decode counter.
REQ-005 The block SHALL run on one clock, with a synchronous, active-low reset.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 Port in_valid, input, 1 bit: upstream opcode valid.
REQ-009 Port in_ready, output, 1 bit: stage can accept an opcode.
REQ-010 Port in_opcode, input, OPCODE_W bits: opcode to decode.
REQ-011 Port out_valid, output, 1 bit: decoded result valid.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 Port out_onehot, output, NUM_OPS bits: registered one-hot decode.
REQ-014 Port out_illegal, output, 1 bit: registered opcode is masked illegal.
REQ-015 Port op_count, output, CNT_W bits: number of accepted opcodes, saturating.
REQ-016 Port trap, output, 1 bit: the stage is halted on an illegal opcode.
REQ-017 Port trap_clr, input, 1 bit: one-cycle pulse that releases the trap.

Function
REQ-018 The stage SHALL accept an opcode when in_valid && in_ready, and SHALL hand off a result when out_valid && out_ready.
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !trap, combinationally.
REQ-020 Latency SHALL be exactly 1 cycle: an opcode accepted at edge N appears on out_* after edge N, giving full throughput of one opcode per cycle.
REQ-021 out_onehot SHALL equal 1<<opcode when the opcode is legal, and SHALL be all zero with out_illegal=1 when LEGAL_MASK[opcode]=0.
REQ-022 While out_valid && !out_ready, out_onehot and out_illegal SHALL hold stable.
REQ-023 When a hand-off occurs with no new accept, out_valid SHALL deassert on the next edge.
REQ-024 When a hand-off and an accept occur in the same cycle, out_valid SHALL stay 1 and the new result SHALL load.
REQ-025 op_count SHALL increment by 1 on each accept, legal or illegal, and SHALL saturate at 2**CNT_W-1 with no wrap.
REQ-026 When out_valid=0, out_onehot and out_illegal SHALL be 0.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL force out_valid=0, out_onehot=0, out_illegal=0, op_count=0, trap=0, and trap FSM state RUN.
REQ-028 While rst_n=0, in_ready SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held result without hand-off.

Configuration
REQ-030 Macro OPCODE_DECODE_TRAP_EN SHALL select the illegal-opcode trap feature.
REQ-031 With OPCODE_DECODE_TRAP_EN defined, an FSM with states RUN and TRAP SHALL apply: RUN->TRAP on accepting an illegal opcode; TRAP->RUN on trap_clr=1; trap=1 exactly in TRAP.
REQ-032 With OPCODE_DECODE_TRAP_EN defined, an illegal accept coinciding with trap_clr SHALL enter TRAP, and trap_clr SHALL be ignored while in RUN.
REQ-033 With OPCODE_DECODE_TRAP_EN defined, the output register SHALL still drain while in TRAP.
REQ-034 Without OPCODE_DECODE_TRAP_EN, trap SHALL be tied 0, trap_clr SHALL be ignored, and illegal opcodes SHALL only flag out_illegal.

Structure
REQ-035 Package opcode_decode_pkg SHALL hold the default OPCODE_W and CNT_W constants and the trap FSM state enum (RUN, TRAP).
REQ-036 The combinational one-hot-plus-legality decode SHALL be a sub-module named onehot_dec, parametrised by OPCODE_W and LEGAL_MASK.

Verification
REQ-037 Reset, then stream opcodes 0..7 with out_ready=1 -> out_onehot 01,02,04,...,80, each one cycle after accept, op_count=8.
REQ-038 Hold out_ready=0 after accepting opcode 5 -> out_onehot=20 stays stable, in_ready=0; release out_ready -> opcode 6 accepted the same cycle.
REQ-039 With LEGAL_MASK=8'h7F, send opcode 7 -> out_onehot=00, out_illegal=1; if TRAP_EN, trap=1 and in_ready=0 until a trap_clr pulse, then opcode 0 is accepted.
REQ-040 With CNT_W=4, accept 20 opcodes -> op_count saturates at 15.
REQ-041 Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, op_count=0, trap=0.
REQ-042 With OPCODE_W=4, send opcode 9 -> out_onehot=16'h0200.
